// File: rtl/mem_pkg.sv
// Shared definitions for the block-copy engine and the data memory it drives.
//   AW                 : width of the address, length and data buses
//   DEFAULT_ADDR_LIMIT : number of words in the data memory (memory depth)
//   state_t            : copy engine controller states
package mem_pkg;

  localparam int AW = 32;
  localparam int unsigned DEFAULT_ADDR_LIMIT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Bundle of the request handshake and the data-memory port of the copy engine.
//   start, src_addr, dst_addr, length : copy request from the requester
//   busy, done, err                   : request status back to the requester
//   mem_read_address, mem_write_address, mem_write_enable, mem_data_in :
//                                       engine-driven memory port signals
//   mem_data_out                      : registered read data from memory
// The engine uses the slave modport; the requester/memory side uses master.
interface mem_copy_engine_if;
  import mem_pkg::*;

  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW-1:0] length;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] mem_read_address;
  logic [AW-1:0] mem_write_address;
  logic          mem_write_enable;
  logic [AW-1:0] mem_data_in;
  logic [AW-1:0] mem_data_out;

  modport slave (
    input  start, src_addr, dst_addr, length, mem_data_out,
    output busy, done, err,
    output mem_read_address, mem_write_address, mem_write_enable, mem_data_in
  );

  modport master (
    output start, src_addr, dst_addr, length, mem_data_out,
    input  busy, done, err,
    input  mem_read_address, mem_write_address, mem_write_enable, mem_data_in
  );

endinterface

// File: rtl/copy_range_check.sv
// Combinational legality check for a copy request.
//   src_i : first source word address
//   dst_i : first destination word address
//   len_i : word count
//   err_o : 1 when the request must be rejected
// A request is rejected when either range runs past the end of memory, or when
// the destination starts strictly inside the source window beyond src+1, where
// an ascending pipelined copy would overwrite source words before reading them.
module copy_range_check
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = DEFAULT_ADDR_LIMIT
) (
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [AW-1:0] len_i,
  output logic          err_o
);

  logic [AW:0] src33;
  logic [AW:0] dst33;
  logic [AW:0] len33;
  logic [AW:0] limit33;
  logic [AW:0] srcEnd;
  logic [AW:0] dstEnd;
  logic [AW:0] srcNext;

  // Everything is widened by one bit so that sums near the top of the
  // address space cannot wrap and sneak past the bound comparison.
  always_comb begin
    src33   = {1'b0, src_i};
    dst33   = {1'b0, dst_i};
    len33   = {1'b0, len_i};
    limit33 = (AW+1)'(ADDR_LIMIT);
    srcEnd  = src33 + len33;
    dstEnd  = dst33 + len33;
    srcNext = src33 + (AW+1)'(1);
    err_o   = (srcEnd > limit33) ||
              (dstEnd > limit33) ||
              ((srcNext < dst33) && (dst33 < srcEnd));
  end

endmodule

// File: rtl/mem_copy_engine.sv
// Block-copy initiator for the single-port-write, registered-read data memory.
// Copies length consecutive words from src_addr to dst_addr while holding busy
// so an external mux hands it the memory port.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset; aborts a copy with no done pulse
//   bus : mem_copy_engine_if.slave
//         request  : start, src_addr, dst_addr, length
//         status   : busy, done (one-cycle pulse), err (valid with done)
//         memory   : mem_read_address, mem_write_address, mem_write_enable,
//                    mem_data_in (out), mem_data_out (in, 1-cycle latency)
// Reads are issued one per cycle in STREAM; each word returned by memory is
// passed straight through to the write port one cycle later, so writes trail
// reads by one cycle and DRAIN covers the final trailing write.
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = DEFAULT_ADDR_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  mem_copy_engine_if.slave bus
);

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] srcAddr_q;
  logic [AW-1:0] dstAddr_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] rdAddr_q;
  logic [AW-1:0] wrAddr_q;
  logic          wrValid_q;
  logic          done_q;
  logic          err_q;
  logic          rangeErr;
  logic          lastRead;

  copy_range_check #(
    .ADDR_LIMIT(ADDR_LIMIT)
  ) rangeCheck (
    .src_i(srcAddr_q),
    .dst_i(dstAddr_q),
    .len_i(len_q),
    .err_o(rangeErr)
  );

  assign lastRead = (cnt_q == (len_q - AW'(1)));

  // Controller state register; reset always returns to IDLE so a copy in
  // flight is abandoned at the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Start is only looked at in IDLE, so re-pulsing start
  // during a copy has no effect. Rejected and empty requests skip straight
  // to DONE without touching memory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CHECK;
      CHECK:   state_d = (rangeErr || (len_q == '0)) ? DONE : STREAM;
      STREAM:  if (lastRead) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers. The request is captured on an accepted start and
  // err is cleared there so it stays valid from the previous request until
  // the next one is accepted. Read and write addresses only advance when
  // another access follows, so after a copy they hold the last address used.
  // wrValid_q marks the cycle where the word read one edge earlier is on
  // mem_data_out and must be written.
  always_ff @(posedge clk) begin
    if (rst) begin
      srcAddr_q <= '0;
      dstAddr_q <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      rdAddr_q  <= '0;
      wrAddr_q  <= '0;
      wrValid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wrValid_q <= (state_q == STREAM);
      done_q    <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            srcAddr_q <= bus.src_addr;
            dstAddr_q <= bus.dst_addr;
            len_q     <= bus.length;
            err_q     <= 1'b0;
          end
        end
        CHECK: begin
          err_q <= rangeErr;
          if (!rangeErr && (len_q != '0)) begin
            cnt_q    <= '0;
            rdAddr_q <= srcAddr_q;
            wrAddr_q <= dstAddr_q;
          end
        end
        STREAM: begin
          if (!lastRead) begin
            cnt_q    <= cnt_q + AW'(1);
            rdAddr_q <= rdAddr_q + AW'(1);
          end
          if (wrValid_q) begin
            wrAddr_q <= wrAddr_q + AW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode. busy covers CHECK through the final write in DRAIN and is
  // already low by the time the done pulse appears. Write data is a direct
  // pass-through of the memory read port, gated to zero when not writing.
  always_comb begin
    bus.busy              = (state_q == CHECK) || (state_q == STREAM) ||
                            (state_q == DRAIN);
    bus.done              = done_q;
    bus.err               = err_q;
    bus.mem_read_address  = rdAddr_q;
    bus.mem_write_address = wrAddr_q;
    bus.mem_write_enable  = wrValid_q;
    bus.mem_data_in       = wrValid_q ? bus.mem_data_out : '0;
  end

endmodule
